// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the 5-bit LFSR pattern stream (x^5+x^3+1).
// Self-synchronises to the incoming states, then flywheels its own prediction
// and flags/counts every mismatch while locked.
module lfsr_sequence_checker #(
    parameter int unsigned LOCK_COUNT    = 3,
    parameter int unsigned LOSS_THRESH   = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [4:0]               sample,
    output logic                     locked,
    output logic                     error_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     lock_lost
);

    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MissW  = $clog2(LOSS_THRESH + 1);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e                   state_q, state_d;
    logic [MatchW-1:0]        match_cnt_q, match_cnt_d;
    logic [MissW-1:0]         miss_cnt_q, miss_cnt_d;
    logic [4:0]               prev_q, prev_d;
    logic [4:0]               expected_q, expected_d;
    logic                     have_prev_q, have_prev_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     error_pulse_q, error_pulse_d;
    logic                     lock_lost_q, lock_lost_d;

    // Generator's next-state function; must stay identical to the transmit side.
    function automatic logic [4:0] lfsr_next(input logic [4:0] s);
        return {s[0] ^ s[2], s[4:1]};
    endfunction

    // Next-state logic for search/lock tracking, error counting and pulses.
    always_comb begin
        state_d       = state_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        prev_d        = prev_q;
        expected_d    = expected_q;
        have_prev_d   = have_prev_q;
        err_count_d   = err_count_q;
        error_pulse_d = 1'b0;
        lock_lost_d   = 1'b0;

        if (sample_valid) begin
            unique case (state_q)
                StSearch: begin
                    if (sample == 5'b00000) begin
                        // All-zero is off the sequence: forget history entirely.
                        match_cnt_d = '0;
                        have_prev_d = 1'b0;
                    end else if (!have_prev_q) begin
                        prev_d      = sample;
                        have_prev_d = 1'b1;
                        match_cnt_d = '0;
                    end else if (sample == lfsr_next(prev_q)) begin
                        prev_d = sample;
                        if (match_cnt_q == MatchW'(LOCK_COUNT - 1)) begin
                            state_d     = StLocked;
                            expected_d  = lfsr_next(sample);
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                        prev_d      = sample;
                    end
                end
                StLocked: begin
                    // Flywheel: prediction advances whatever arrives, so one bad
                    // sample cannot corrupt the following comparisons.
                    expected_d = lfsr_next(expected_q);
                    if (sample == expected_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        error_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (miss_cnt_q == MissW'(LOSS_THRESH - 1)) begin
                            state_d     = StSearch;
                            lock_lost_d = 1'b1;
                            have_prev_d = 1'b0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StSearch;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            prev_q        <= '0;
            expected_q    <= '0;
            have_prev_q   <= 1'b0;
            err_count_q   <= '0;
            error_pulse_q <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            prev_q        <= prev_d;
            expected_q    <= expected_d;
            have_prev_q   <= have_prev_d;
            err_count_q   <= err_count_d;
            error_pulse_q <= error_pulse_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign locked      = (state_q == StLocked);
    assign error_pulse = error_pulse_q;
    assign err_count   = err_count_q;
    assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Directed bench for lfsr_sequence_checker; a second instance with a 4-bit
// error counter shares the stimulus to exercise saturation.
module tb_lfsr_sequence_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [4:0]  sample = 5'b00000;
    logic        locked, error_pulse, lock_lost;
    logic [15:0] err_count;
    logic        locked4, error_pulse4, lock_lost4;
    logic [3:0]  err_count4;

    int checks = 0;
    int failures = 0;
    int idx = 0;
    int exp_err = 0;

    // One full period of x^5+x^3+1 starting at 00001, worked out by hand.
    logic [4:0] seq [0:30] = '{
        5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b10010, 5'b01001, 5'b10100, 5'b11010,
        5'b01101, 5'b00110, 5'b10011, 5'b11001, 5'b11100, 5'b11110, 5'b11111, 5'b01111,
        5'b00111, 5'b00011, 5'b10001, 5'b11000, 5'b01100, 5'b10110, 5'b11011, 5'b11101,
        5'b01110, 5'b10111, 5'b01011, 5'b10101, 5'b01010, 5'b00101, 5'b00010
    };

    lfsr_sequence_checker dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .locked       (locked),
        .error_pulse  (error_pulse),
        .err_count    (err_count),
        .lock_lost    (lock_lost)
    );

    lfsr_sequence_checker #(.ERR_CNT_WIDTH(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .locked       (locked4),
        .error_pulse  (error_pulse4),
        .err_count    (err_count4),
        .lock_lost    (lock_lost4)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] cur();
        return seq[idx % 31];
    endfunction

    // Present one input for one clock; outputs are then observed #1 after the edge.
    task automatic step(input logic v, input logic [4:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample_valid = 1'b1;
        sample = 5'b00001;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sample_valid = 1'b0;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL reset_error_pulse got=%b exp=0", error_pulse); end
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        checks++; if (err_count4 !== 4'd0) begin failures++; $display("FAIL reset_err_count4 got=%0d exp=0", err_count4); end
    endtask

    task automatic test_clean_lock();
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, cur());
            idx++;
            checks++; if (locked !== 1'(k >= 3)) begin failures++; $display("FAIL clean_locked k=%0d got=%b exp=%b", k, locked, 1'(k >= 3)); end
            checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL clean_error_pulse k=%0d got=%b exp=0", k, error_pulse); end
        end
        for (int k = 0; k < 100; k++) begin
            step(1'b1, cur());
            idx++;
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL run_locked k=%0d got=%b exp=1", k, locked); end
            checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL run_error_pulse k=%0d got=%b exp=0", k, error_pulse); end
        end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clean_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, cur());
            idx++;
            checks++; if (locked !== 1'(k >= 3)) begin failures++; $display("FAIL gap_locked k=%0d got=%b exp=%b", k, locked, 1'(k >= 3)); end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 5'b11111);
                checks++; if (locked !== 1'(k >= 3)) begin failures++; $display("FAIL gap_hold_locked k=%0d got=%b exp=%b", k, locked, 1'(k >= 3)); end
                checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL gap_error_pulse k=%0d got=%b exp=0", k, error_pulse); end
            end
        end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL gap_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_single_error();
        while (idx % 31 != 4) begin
            step(1'b1, cur());
            idx++;
        end
        step(1'b1, 5'b10011);  // corrupts 10010
        idx++;
        exp_err = 1;
        checks++; if (error_pulse !== 1'b1) begin failures++; $display("FAIL single_error_pulse got=%b exp=1", error_pulse); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL single_err_count got=%0d exp=1", err_count); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL single_locked got=%b exp=1", locked); end
        step(1'b1, cur());
        idx++;
        checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL single_next_pulse got=%b exp=0", error_pulse); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL single_next_count got=%0d exp=1", err_count); end
        // Three more misses only stay under the loss threshold if the earlier miss was cleared.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, cur() ^ 5'b01000);
            idx++;
            exp_err++;
            checks++; if (error_pulse !== 1'b1) begin failures++; $display("FAIL miss_clear_pulse k=%0d got=%b exp=1", k, error_pulse); end
            checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL miss_clear_lock_lost k=%0d got=%b exp=0", k, lock_lost); end
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL miss_clear_locked k=%0d got=%b exp=1", k, locked); end
        end
        step(1'b1, cur());
        idx++;
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL miss_clear_after_locked got=%b exp=1", locked); end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL miss_clear_err_count got=%0d exp=%0d", err_count, exp_err); end
    endtask

    task automatic test_lock_loss();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 5'b00000);
            idx++;
            exp_err++;
            checks++; if (error_pulse !== 1'b1) begin failures++; $display("FAIL loss_pulse k=%0d got=%b exp=1", k, error_pulse); end
            checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL loss_err_count k=%0d got=%0d exp=%0d", k, err_count, exp_err); end
            checks++; if (locked !== 1'(k < 3)) begin failures++; $display("FAIL loss_locked k=%0d got=%b exp=%b", k, locked, 1'(k < 3)); end
            checks++; if (lock_lost !== 1'(k == 3)) begin failures++; $display("FAIL loss_lock_lost k=%0d got=%b exp=%b", k, lock_lost, 1'(k == 3)); end
        end
        step(1'b0, 5'b00000);
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL loss_pulse_width got=%b exp=0", lock_lost); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_stays_unlocked got=%b exp=0", locked); end
        idx += 10;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, cur());
            idx++;
            checks++; if (locked !== 1'(k == 3)) begin failures++; $display("FAIL relock k=%0d got=%b exp=%b", k, locked, 1'(k == 3)); end
            checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL relock_pulse k=%0d got=%b exp=0", k, error_pulse); end
        end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL relock_err_count got=%0d exp=%0d", err_count, exp_err); end
    endtask

    task automatic test_saturation();
        int exp4;
        do_reset();
        idx = 3;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, cur());
            idx++;
        end
        checks++; if (locked4 !== 1'b1) begin failures++; $display("FAIL sat_lock got=%b exp=1", locked4); end
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, cur());
            idx++;
            checks++; if (error_pulse4 !== 1'b0) begin failures++; $display("FAIL sat_good_pulse n=%0d got=%b exp=0", n, error_pulse4); end
            step(1'b1, cur() ^ 5'b00010);
            idx++;
            exp4 = (n > 15) ? 15 : n;
            checks++; if (error_pulse4 !== 1'b1) begin failures++; $display("FAIL sat_bad_pulse n=%0d got=%b exp=1", n, error_pulse4); end
            checks++; if (err_count4 !== 4'(exp4)) begin failures++; $display("FAIL sat_count4 n=%0d got=%0d exp=%0d", n, err_count4, exp4); end
            checks++; if (err_count !== 16'(n)) begin failures++; $display("FAIL sat_count16 n=%0d got=%0d exp=%0d", n, err_count, n); end
            checks++; if (locked4 !== 1'b1 || lock_lost4 !== 1'b0) begin failures++; $display("FAIL sat_no_loss n=%0d got=%b%b exp=10", n, locked4, lock_lost4); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        idx = 12;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, cur());
            idx++;
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, cur() ^ 5'b10000);
            idx++;
            step(1'b1, cur());
            idx++;
        end
        checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", err_count); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mid_pre_locked got=%b exp=1", locked); end
        reset = 1'b1;
        step(1'b1, cur() ^ 5'b00100);
        reset = 1'b0;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_locked got=%b exp=0", locked); end
        checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL mid_error_pulse got=%b exp=0", error_pulse); end
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL mid_lock_lost got=%b exp=0", lock_lost); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL mid_err_count got=%0d exp=0", err_count); end
        idx += 5;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, cur());
            idx++;
            checks++; if (locked !== 1'(k == 3)) begin failures++; $display("FAIL mid_relock k=%0d got=%b exp=%b", k, locked, 1'(k == 3)); end
            checks++; if (error_pulse !== 1'b0) begin failures++; $display("FAIL mid_relock_pulse k=%0d got=%b exp=0", k, error_pulse); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_valid_gaps();
        test_single_error();
        test_lock_loss();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
